// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, E/M write ports and machine status.
// The master drives indices, write data and status; the slave returns read data and latched status.
interface reg_file_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
);
  logic              stall;
  logic [ADDR_W-1:0] srcA;
  logic [ADDR_W-1:0] srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [ADDR_W-1:0] dstE;
  logic [ADDR_W-1:0] dstM;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic [2:0]        stat_in;
  logic [2:0]        stat_out;
  logic              halted;

  modport master (
    output stall, srcA, srcB, dstE, dstM, valE, valM, stat_in,
    input  valA, valB, stat_out, halted
  );

  modport slave (
    input  stall, srcA, srcB, dstE, dstM, valE, valM, stat_in,
    output valA, valB, stat_out, halted
  );
endinterface

// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with a RUN/HALTED status machine.
// Optional REG_FILE_MP_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file_mp #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  reg_file_mp_if.slave  bus
);

  localparam int                NREG  = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] RNONE = ADDR_W'(NREG);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t            state_q;
  logic [2:0]        stat_out_q;
  logic              halted_q;
  logic [DATA_W-1:0] regs_q [NREG];

  logic       commit;
  logic       faultEdge;
  logic       writeE;
  logic       writeM;
  logic [2:0] haltStat_d;

  // An edge commits only in RUN, unstalled, with a good instruction; a fault commits nothing.
  always_comb begin
    commit    = (state_q == RUN) && !bus.stall && (bus.stat_in == STAT_AOK);
    faultEdge = (state_q == RUN) && !bus.stall && (bus.stat_in != STAT_AOK);
    writeM    = commit && (bus.dstM != RNONE);
    writeE    = commit && (bus.dstE != RNONE) && (bus.dstE != bus.dstM);
  end

  always_comb begin
    haltStat_d = STAT_INS;
    if ((bus.stat_in == STAT_HLT) || (bus.stat_in == STAT_ADR) ||
        (bus.stat_in == STAT_INS)) begin
      haltStat_d = bus.stat_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      stat_out_q <= STAT_AOK;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (faultEdge) begin
            state_q    <= HALTED;
            stat_out_q <= haltStat_d;
            halted_q   <= 1'b1;
          end
        end
        HALTED: begin
          state_q    <= HALTED;
          halted_q   <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          stat_out_q <= STAT_AOK;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  // writeE is already suppressed on a dstE == dstM collision, so the M port wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
    end else begin
      if (writeE) begin
        regs_q[bus.dstE] <= bus.valE;
      end
      if (writeM) begin
        regs_q[bus.dstM] <= bus.valM;
      end
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] src);
    logic [DATA_W-1:0] result;
    result = '0;
    if (src != RNONE) begin
`ifdef REG_FILE_MP_BYPASS_EN
      if (writeM && (bus.dstM == src)) begin
        result = bus.valM;
      end else if (writeE && (bus.dstE == src)) begin
        result = bus.valE;
      end else begin
        result = regs_q[src];
      end
`else
      result = regs_q[src];
`endif
    end
    return result;
  endfunction

  always_comb begin
    bus.valA = readPort(bus.srcA);
    bus.valB = readPort(bus.srcB);
  end

  assign bus.stat_out = stat_out_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized self-checking bench for reg_file_mp against an array-based reference model.
// Honours REG_FILE_MP_BYPASS_EN so expected read data matches the configured build.
module tb_reg_file_mp;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int NREG   = 15;
  localparam logic [3:0] RNONE = 4'd15;

  logic clk;
  logic rst;

  reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors;
  int checks;

  logic [63:0] model [NREG];
  bit          mHalted;
  logic [2:0]  mStat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of registers plus a halted flag and status code.
  task automatic modelReset();
    for (int i = 0; i < NREG; i++) model[i] = 64'(i);
    mHalted = 1'b0;
    mStat   = 3'd1;
  endtask

  task automatic modelEdge();
    if (!mHalted && !bus.stall) begin
      if (bus.stat_in == 3'd1) begin
        if (bus.dstE != RNONE) model[bus.dstE] = bus.valE;
        if (bus.dstM != RNONE) model[bus.dstM] = bus.valM;
      end else begin
        mHalted = 1'b1;
        mStat   = (bus.stat_in inside {3'd2, 3'd3, 3'd4}) ? bus.stat_in : 3'd4;
      end
    end
  endtask

  function automatic logic [63:0] expRead(input logic [3:0] src);
    if (src == RNONE) return 64'd0;
`ifdef REG_FILE_MP_BYPASS_EN
    if (!mHalted && !bus.stall && bus.stat_in == 3'd1) begin
      if (bus.dstM == src) return bus.valM;
      if (bus.dstE == src) return bus.valE;
    end
`endif
    return model[src];
  endfunction

  task automatic setIdle();
    bus.stall   = 1'b0;
    bus.dstE    = RNONE;
    bus.dstM    = RNONE;
    bus.valE    = '0;
    bus.valM    = '0;
    bus.stat_in = 3'd1;
    bus.srcA    = 4'd0;
    bus.srcB    = 4'd0;
  endtask

  task automatic step();
    modelEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    setIdle();
    pulseReset();
    for (int i = 0; i < NREG; i++) begin
      bus.srcA = 4'(i);
      bus.srcB = 4'(NREG - 1 - i);
      #1;
      checks++;
      if (bus.valA !== 64'(i)) begin
        errors++;
        $display("[TB] FAIL reset_valA[%0d]: got %h expected %h", i, bus.valA, 64'(i));
      end
      checks++;
      if (bus.valB !== 64'(NREG - 1 - i)) begin
        errors++;
        $display("[TB] FAIL reset_valB[%0d]: got %h expected %h", i, bus.valB, 64'(NREG - 1 - i));
      end
    end
    bus.srcA = 4'd3;
    bus.srcB = 4'd14;
    #1;
    checks++;
    if (bus.valA !== 64'd3 || bus.valB !== 64'd14) begin
      errors++;
      $display("[TB] FAIL reset_read_3_14: got %h/%h expected 3/14", bus.valA, bus.valB);
    end
    bus.srcA = RNONE;
    #1;
    checks++;
    if (bus.valA !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_rnone: got %h expected 0", bus.valA);
    end
    checks++;
    if (bus.stat_out !== 3'd1 || bus.halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status: got stat=%0d halted=%0b expected stat=1 halted=0", bus.stat_out, bus.halted);
    end
  endtask

  task automatic test_port_priority();
    $display("[TB] test_port_priority");
    setIdle();
    bus.dstE = 4'd2; bus.valE = 64'hAAAA;
    bus.dstM = 4'd2; bus.valM = 64'h5555;
    step();
    setIdle();
    bus.dstE = 4'd4; bus.valE = 64'h1234;
    bus.dstM = RNONE; bus.valM = 64'hDEAD;
    step();
    setIdle();
    for (int i = 0; i < NREG; i++) begin
      logic [63:0] want;
      want = (i == 2) ? 64'h5555 : (i == 4) ? 64'h1234 : 64'(i);
      bus.srcA = 4'(i);
      #1;
      checks++;
      if (bus.valA !== want) begin
        errors++;
        $display("[TB] FAIL priority_reg[%0d]: got %h expected %h", i, bus.valA, want);
      end
    end
  endtask

  task automatic test_halt();
    $display("[TB] test_halt");
    pulseReset();
    setIdle();
    bus.stat_in = 3'd2;
    bus.dstE = 4'd5; bus.valE = 64'hFF;
    step();
    checks++;
    if (bus.halted !== 1'b1 || bus.stat_out !== 3'd2) begin
      errors++;
      $display("[TB] FAIL halt_status: got stat=%0d halted=%0b expected stat=2 halted=1", bus.stat_out, bus.halted);
    end
    bus.stat_in = 3'd1;
    bus.valE = 64'hABCD;
    step();
    bus.stat_in = 3'd3;
    step();
    setIdle();
    bus.srcA = 4'd5;
    #1;
    checks++;
    if (bus.valA !== 64'd5) begin
      errors++;
      $display("[TB] FAIL halt_no_write: got %h expected 5", bus.valA);
    end
    checks++;
    if (bus.halted !== 1'b1 || bus.stat_out !== 3'd2) begin
      errors++;
      $display("[TB] FAIL halt_terminal: got stat=%0d halted=%0b expected stat=2 halted=1", bus.stat_out, bus.halted);
    end
  endtask

  task automatic test_stall();
    $display("[TB] test_stall");
    pulseReset();
    setIdle();
    bus.stall = 1'b1;
    bus.stat_in = 3'd3;
    bus.dstE = 4'd6; bus.valE = 64'h77;
    step();
    step();
    bus.srcA = 4'd6;
    #1;
    checks++;
    if (bus.valA !== 64'd6 || bus.stat_out !== 3'd1 || bus.halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_hold: got reg6=%h stat=%0d halted=%0b expected 6/1/0", bus.valA, bus.stat_out, bus.halted);
    end
    bus.stall = 1'b0;
    step();
    setIdle();
    bus.srcA = 4'd6;
    #1;
    checks++;
    if (bus.halted !== 1'b1 || bus.stat_out !== 3'd3 || bus.valA !== 64'd6) begin
      errors++;
      $display("[TB] FAIL stall_release: got stat=%0d halted=%0b reg6=%h expected 3/1/6", bus.stat_out, bus.halted, bus.valA);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] wantPre;
    $display("[TB] test_bypass");
    pulseReset();
    setIdle();
`ifdef REG_FILE_MP_BYPASS_EN
    wantPre = 64'h99;
`else
    wantPre = 64'd7;
`endif
    bus.srcA = 4'd7;
    bus.dstM = 4'd7; bus.valM = 64'h99;
    #1;
    checks++;
    if (bus.valA !== wantPre) begin
      errors++;
      $display("[TB] FAIL bypass_pre_edge: got %h expected %h", bus.valA, wantPre);
    end
    step();
    bus.dstM = RNONE;
    #1;
    checks++;
    if (bus.valA !== 64'h99) begin
      errors++;
      $display("[TB] FAIL bypass_post_edge: got %h expected 99", bus.valA);
    end
  endtask

  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    setIdle();
    bus.stat_in = 3'd7;
    step();
    checks++;
    if (bus.halted !== 1'b1 || bus.stat_out !== 3'd4) begin
      errors++;
      $display("[TB] FAIL async_pre_halt: got stat=%0d halted=%0b expected 4/1", bus.stat_out, bus.halted);
    end
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checks++;
    if (bus.halted !== 1'b0 || bus.stat_out !== 3'd1) begin
      errors++;
      $display("[TB] FAIL async_immediate: got stat=%0d halted=%0b expected 1/0", bus.stat_out, bus.halted);
    end
    bus.stat_in = 3'd1;
    bus.dstE = 4'd3; bus.valE = 64'hBEEF;
    bus.dstM = 4'd7; bus.valM = 64'hCAFE;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NREG; i++) begin
      bus.srcA = 4'(i);
      #1;
      checks++;
      if (bus.valA !== 64'(i)) begin
        errors++;
        $display("[TB] FAIL async_reg[%0d]: got %h expected %h", i, bus.valA, 64'(i));
      end
    end
    rst = 1'b0;
    setIdle();
    bus.stat_in = 3'd6;
    step();
    checks++;
    if (bus.halted !== 1'b1 || bus.stat_out !== 3'd4) begin
      errors++;
      $display("[TB] FAIL async_resume_ins: got stat=%0d halted=%0b expected 4/1", bus.stat_out, bus.halted);
    end
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    pulseReset();
    for (int n = 0; n < 400; n++) begin
      bus.stall   = ($urandom_range(0, 5) == 0);
      bus.stat_in = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      bus.dstE    = 4'($urandom_range(0, 15));
      bus.dstM    = ($urandom_range(0, 3) == 0) ? bus.dstE : 4'($urandom_range(0, 15));
      bus.valE    = {$urandom, $urandom};
      bus.valM    = {$urandom, $urandom};
      bus.srcA    = 4'($urandom_range(0, 15));
      bus.srcB    = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (bus.valA !== expRead(bus.srcA)) begin
        errors++;
        $display("[TB] FAIL rand_valA[%0d]: src=%0d got %h expected %h", n, bus.srcA, bus.valA, expRead(bus.srcA));
      end
      checks++;
      if (bus.valB !== expRead(bus.srcB)) begin
        errors++;
        $display("[TB] FAIL rand_valB[%0d]: src=%0d got %h expected %h", n, bus.srcB, bus.valB, expRead(bus.srcB));
      end
      step();
      checks++;
      if (bus.halted !== mHalted || bus.stat_out !== mStat) begin
        errors++;
        $display("[TB] FAIL rand_status[%0d]: got stat=%0d halted=%0b expected stat=%0d halted=%0b", n, bus.stat_out, bus.halted, mStat, mHalted);
      end
      if (mHalted && $urandom_range(0, 3) == 0) pulseReset();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    setIdle();
    modelReset();
    test_reset();
    test_port_priority();
    test_halt();
    test_stall();
    test_bypass();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 64: register data width in bits.
REQ-002 Parameter ADDR_W, default 4: register index width; index 2^ADDR_W-1 is RNONE, so registers 0..2^ADDR_W-2 are implemented (15 at default).
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: asynchronous active-high reset.
REQ-005 Port stall  input  1: 1 = freeze; no register write, no status update this cycle.
REQ-006 Ports srcA, srcB  input  ADDR_W: read indices.
REQ-007 Ports valA, valB  output  DATA_W: read data for srcA, srcB.
REQ-008 Ports dstE, dstM  input  ADDR_W: write indices for E and M write ports.
REQ-009 Ports valE, valM  input  DATA_W: write data for E and M ports.
REQ-010 Port stat_in  input  3: instruction status (1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-011 Port stat_out  output  3: latched machine status.
REQ-012 Port halted  output  1: 1 when the block is in state HALTED.

Function
REQ-013 Reads SHALL be combinational; srcX = RNONE SHALL yield valX = 0.
REQ-014 On a rising edge with rst=0, stall=0 and state RUN, reg[dstE] <= valE and reg[dstM] <= valM, each only if its index != RNONE.
REQ-015 If dstE == dstM != RNONE on the same edge, reg gets valM (M port wins); the E write is dropped.
REQ-016 State machine: RUN, HALTED; reset enters RUN.
REQ-017 RUN -> HALTED on a rising edge with stall=0 and stat_in != 1; stat_out <= stat_in on that edge.
REQ-018 The transition edge SHALL NOT perform the register writes of REQ-014 (faulting instruction commits nothing).
REQ-019 HALTED is terminal until rst; no writes, stat_out held, stat_in and stall ignored.
REQ-020 stat_in values 0, 5, 6, 7 SHALL be treated as INS: halt with stat_out = 4.
REQ-021 In RUN with stall=0 and stat_in = 1, stat_out stays 1.
REQ-022 halted = 1 iff state is HALTED; purely registered, no combinational path from stat_in.
REQ-023 stall=1 in RUN SHALL hold all registers, state and stat_out unchanged.
REQ-024 Writes of DATA_W-bit values SHALL store all bits unmodified; no sign or width change.

Reset
REQ-025 rst=1 SHALL asynchronously set reg[i] = i (zero-extended to DATA_W) for every implemented i, state = RUN, stat_out = 1, halted = 0.
REQ-026 rst asserted mid-cycle SHALL take effect immediately and override any write on a coincident edge; deassertion resumes normal operation on the next rising edge.

Configuration
REQ-027 Macro REG_FILE_MP_BYPASS_EN defined: valA/valB SHALL forward same-cycle write data when srcX equals a dstE/dstM that will be written this edge (REQ-014 conditions true), with M taking priority over E, and otherwise the stored value.
REQ-028 Macro REG_FILE_MP_BYPASS_EN undefined: valA/valB SHALL return the stored value only; new data visible the cycle after the write.

Verification
REQ-029 Reset then read srcA=3, srcB=14 -> valA=3, valB=14; srcA=15 -> valA=0; stat_out=1, halted=0.
REQ-030 dstE=2 valE=0xAAAA, dstM=2 valM=0x5555, one edge -> reg[2]=0x5555; dstE=4 valE=0x1234 dstM=15 -> reg[4]=0x1234, nothing else changes.
REQ-031 stat_in=2 with dstE=5 valE=0xFF on one edge -> halted=1, stat_out=2, reg[5] still 5; subsequent stat_in=1 writes to reg[5] ignored.
REQ-032 stall=1 with dstE=6 valE=0x77 and stat_in=3 -> reg[6]=6, stat_out=1, halted=0; drop stall -> halts with stat_out=3.
REQ-033 With REG_FILE_MP_BYPASS_EN: srcA=7, dstM=7 valM=0x99 before edge -> valA=0x99 pre-edge; without macro -> valA=7 pre-edge, 0x99 post-edge.
REQ-034 Assert rst between edges while HALTED with stat_out=4 -> immediately reg[i]=i, stat_out=1, halted=0; stat_in=6 later -> stat_out=4.
